// File: rtl/digit_control.sv
// -----------------------------------------------------------------------------
// digit_control
//
// Upstream stage of the MAX7219 matrix driver. Conditions three raw
// push-buttons and turns them into a 0..9 digit plus a display enable.
// The modes are MANUAL (up/down counting), AUTO (timed stepping) and
// BLANK (idle timeout).
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   btn_up         : raw up button, active high, asynchronous to clk
//   btn_down       : raw down button, active high, asynchronous to clk
//   btn_mode       : raw mode button, active high, asynchronous to clk
//   digit          : current digit, always 0..9
//   display_active : 1 = show digit, 0 = blank
//   mode           : 0 = MANUAL, 1 = AUTO, 2 = BLANK
// -----------------------------------------------------------------------------
module digit_control #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int AUTO_PERIOD     = 500,
    parameter int IDLE_TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [3:0] digit,
    output logic       display_active,
    output logic [1:0] mode
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int AUTO_W = $clog2(AUTO_PERIOD);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        BLANK  = 2'd2
    } state_t;

    logic [2:0] raw_btn;
    logic [2:0] press;
    logic [1:0] fill_q;
    logic       fill_done;

    assign raw_btn = {btn_mode, btn_down, btn_up};

    // The synchronisers hold reset values for two edges after reset release.
    // fill_done marks the point where their output reflects the real pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 2'd0;
        end else if (fill_q != 2'd2) begin
            fill_q <= fill_q + 2'd1;
        end
    end
    assign fill_done = (fill_q == 2'd2);

    // -------------------------------------------------------------------------
    // Per-button synchroniser, debounce and press-pulse generation
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             deb_q;
            logic             deb_prev_q;
            logic             armed_q;
            logic             press_q;
            logic [DEB_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    armed_q    <= 1'b0;
                    press_q    <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    sync1_q <= raw_btn[gi];
                    sync2_q <= sync1_q;

                    if (sync2_q == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_MAX) begin
                        deb_q <= ~deb_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end

                    deb_prev_q <= deb_q;

                    // A button held through reset release must not count as a
                    // press. Presses are enabled only once the settled
                    // synchroniser output has been seen low.
                    if (fill_done && !sync2_q) begin
                        armed_q <= 1'b1;
                    end

                    press_q <= deb_q & ~deb_prev_q & armed_q;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic press_up;
    logic press_down;
    logic press_mode;
    logic any_press;

    assign press_up   = press[0];
    assign press_down = press[1];
    assign press_mode = press[2];
    assign any_press  = |press;

    // -------------------------------------------------------------------------
    // Mode state machine
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        digit_q, digit_d;
    logic              disp_q, disp_d;
    logic              dir_up_q, dir_up_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [AUTO_W-1:0] tick_q, tick_d;
    logic [3:0]        digit_inc;
    logic [3:0]        digit_dec;
    logic              step_up;

    // The >=9 and >9 tests also pull any out-of-range value back into 0..9.
    assign digit_inc = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
    assign digit_dec = (digit_q == 4'd0 || digit_q > 4'd9) ? 4'd9 : digit_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        dir_up_d = dir_up_q;
        idle_d   = idle_q;
        tick_d   = tick_q;
        step_up  = dir_up_q;

        case (state_q)
            MANUAL: begin
                if (press_mode) begin
                    state_d  = AUTO;
                    tick_d   = '0;
                    dir_up_d = 1'b1;
                end else if (any_press) begin
                    idle_d = '0;
                    if (press_up && !press_down) begin
                        digit_d = digit_inc;
                    end else if (press_down && !press_up) begin
                        digit_d = digit_dec;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    state_d = BLANK;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            AUTO: begin
                if (press_mode) begin
                    state_d = MANUAL;
                    idle_d  = '0;
                end else begin
                    // A press landing on a tick steers that same tick.
                    if (press_up && !press_down) begin
                        step_up = 1'b1;
                    end else if (press_down && !press_up) begin
                        step_up = 1'b0;
                    end
                    dir_up_d = step_up;

                    if (tick_q == AUTO_MAX) begin
                        tick_d  = '0;
                        digit_d = step_up ? digit_inc : digit_dec;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            BLANK: begin
                // The waking press is consumed and has no other effect.
                if (any_press) begin
                    state_d = MANUAL;
                    idle_d  = '0;
                end
            end

            default: begin
                state_d = MANUAL;
            end
        endcase

        disp_d = (state_d != BLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MANUAL;
            digit_q  <= 4'd0;
            disp_q   <= 1'b1;
            dir_up_q <= 1'b1;
            idle_q   <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            disp_q   <= disp_d;
            dir_up_q <= dir_up_d;
            idle_q   <= idle_d;
            tick_q   <= tick_d;
        end
    end

    assign digit          = digit_q;
    assign display_active = disp_q;
    assign mode           = state_q;

endmodule

// File: tb/tb_digit_control.sv
module tb_digit_control;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [3:0] digit;
    logic       display_active;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {digit, mode, display_active} plus a tag.
    logic [6:0] sb_val[$];
    string      sb_tag[$];

    // Reference state kept by the bench.
    int m_digit;
    int m_mode;
    int m_act;

    digit_control #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (8),
        .IDLE_TIMEOUT   (50)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_mode      (btn_mode),
        .digit         (digit),
        .display_active(display_active),
        .mode          (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap_inc(input int d);
        return (d == 9) ? 0 : d + 1;
    endfunction

    function automatic int wrap_dec(input int d);
        return (d == 0) ? 9 : d - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input string tag);
        logic [3:0] d;
        logic [1:0] m;
        logic       a;
        d = 4'(m_digit);
        m = 2'(m_mode);
        a = 1'(m_act);
        sb_val.push_back({d, m, a});
        sb_tag.push_back(tag);
    endtask

    task automatic compare();
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        string      tag;
        checks++;
        if (sb_val.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0d required=1 entry", sb_val.size());
        end else begin
            exp_v = sb_val.pop_front();
            tag   = sb_tag.pop_front();
            obs_v = {digit, mode, display_active};
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s observed digit=%0d mode=%0d act=%0d expected digit=%0d mode=%0d act=%0d",
                       tag, obs_v[6:3], obs_v[2:1], obs_v[0], exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
            $display("txn %-14s digit=%0d mode=%0d act=%0d", tag, digit, mode, display_active);
        end
    endtask

    // Push expected state, then compare right away.
    task automatic check_now(input string tag);
        push_exp(tag);
        compare();
    endtask

    // Press pattern {mode, down, up} held 6 cycles; the effect lands on the
    // 8th edge after the first sampling edge, which is where this task ends.
    task automatic press_and_check(input logic [2:0] btns, input string tag);
        push_exp(tag);
        {btn_mode, btn_down, btn_up} = btns;
        settle(6);
        {btn_mode, btn_down, btn_up} = 3'b000;
        settle(2);
        compare();
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        m_digit  = 0;
        m_mode   = 0;
        m_act    = 1;

        // ---------------- reset ----------------
        settle(3);
        check_now("reset_held");
        rst_n = 1'b1;
        settle(4);
        check_now("post_reset");

        // ---------------- 1: exact latency ----------------
        push_exp("lat_edge7");
        btn_up = 1'b1;
        settle(7);
        compare();
        m_digit = 1;
        push_exp("lat_edge8");
        tick();
        compare();
        settle(2);
        btn_up = 1'b0;
        settle(12);
        check_now("single_inc");

        // ---------------- 2: bounce, clean presses, wraps ----------------
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1;
            settle(3);
            btn_up = 1'b0;
            tick();
        end
        settle(8);
        check_now("bounce_ignored");

        m_digit = wrap_inc(m_digit);
        press_and_check(3'b001, "clean_up");
        settle(6);
        while (m_digit != 0) begin
            m_digit = wrap_inc(m_digit);
            press_and_check(3'b001, "up_to_zero");
            settle(6);
        end
        for (int i = 0; i < 10; i++) begin
            m_digit = wrap_inc(m_digit);
            press_and_check(3'b001, "up_cycle");
            settle(6);
        end
        check_now("ten_ups_at_0");
        m_digit = wrap_dec(m_digit);
        press_and_check(3'b010, "down_wrap");
        settle(6);

        // ---------------- 3: AUTO mode ----------------
        m_mode = 1;
        press_and_check(3'b100, "enter_auto");
        settle(7);
        check_now("auto_hold");
        tick();
        m_digit = wrap_inc(m_digit);
        check_now("auto_wrap_up");
        settle(8);
        m_digit = wrap_inc(m_digit);
        check_now("auto_step_up");
        // Down press whose effect coincides with a tick: steps down at once.
        m_digit = wrap_dec(m_digit);
        press_and_check(3'b010, "auto_dir_down");
        settle(8);
        m_digit = wrap_dec(m_digit);
        check_now("auto_wrap_dn");
        settle(8);
        m_digit = wrap_dec(m_digit);
        check_now("auto_step_dn");
        // Mode press landing on a tick: back to MANUAL, digit held.
        m_mode = 0;
        press_and_check(3'b100, "exit_auto");
        settle(16);
        check_now("manual_frozen");

        // ---------------- 4: idle blanking ----------------
        while (m_digit != 5) begin
            settle(6);
            m_digit = wrap_dec(m_digit);
            press_and_check(3'b010, "down_to_5");
        end
        settle(49);
        check_now("idle_not_yet");
        tick();
        m_mode = 2;
        m_act  = 0;
        check_now("idle_blank");
        settle(5);
        m_mode = 0;
        m_act  = 1;
        press_and_check(3'b010, "wake_consumed");
        settle(6);
        m_digit = wrap_dec(m_digit);
        press_and_check(3'b010, "down_after_wake");
        settle(6);

        // ---------------- 5: simultaneous presses ----------------
        press_and_check(3'b011, "up_down_same");
        settle(6);
        m_mode = 1;
        press_and_check(3'b101, "mode_up_same");

        // ---------------- 6: reset mid AUTO / mid debounce ----------------
        settle(3);
        btn_up = 1'b1;
        settle(2);
        rst_n = 1'b0;
        #1;
        m_digit = 0;
        m_mode  = 0;
        m_act   = 1;
        check_now("async_reset");
        settle(2);
        rst_n = 1'b1;
        settle(20);
        check_now("held_thru_rst");
        btn_up = 1'b0;
        settle(12);
        check_now("release_no_inc");
        m_digit = 1;
        press_and_check(3'b001, "repress_inc");
        settle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
